// File: rtl/top_level.sv
// Min/max pairwise Hamming distance engine over 32 16-bit words in data memory.
// Define HAMMING_LOC_EN to also store the pair indices of both extremes.

module top_level_dmem (
  input  logic       clk,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);
  logic [7:0] Core [0:255];

  always_ff @(posedge clk) begin
    if (i_we) Core[i_addr] <= i_wdata;
  end

  assign o_rdata = Core[i_addr];
endmodule

module top_level_imem (
  input  logic       clk,
  input  logic       i_we,
  input  logic [9:0] i_addr,
  input  logic [8:0] i_wdata,
  output logic [8:0] o_rdata
);
  logic [8:0] Core [0:1023];

  always_ff @(posedge clk) begin
    if (i_we) Core[i_addr] <= i_wdata;
  end

  assign o_rdata = Core[i_addr];
endmodule

module top_level (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LOADJ, S_SCANK,
    S_WRMIN, S_WRMAX, S_DONE
  } state_t;

  state_t      r_state;
  logic        r_ph;
  logic [4:0]  r_j;
  logic [4:0]  r_k;
  logic [15:0] r_wj;
  logic [7:0]  r_khi;
  logic [4:0]  r_min;
  logic [4:0]  r_max;
  logic        r_done;
`ifdef HAMMING_LOC_EN
  logic [4:0]  r_minj;
  logic [4:0]  r_mink;
  logic [4:0]  r_maxj;
  logic [4:0]  r_maxk;
  logic [1:0]  r_wsel;
`endif

  logic        w_we;
  logic [7:0]  w_addr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic [15:0] w_x;
  logic [4:0]  w_dist;
  logic [8:0]  w_instr_unused;

  top_level_dmem dataMemory (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Kept only so program preloads resolve; never written or consumed.
  top_level_imem instrMem1 (
    .clk     (clk),
    .i_we    (1'b0),
    .i_addr  (10'd0),
    .i_wdata (9'd0),
    .o_rdata (w_instr_unused)
  );

  // Operand address is {index, byte}; byte 0 is the high byte.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = 8'd0;
    w_wdata = 8'd0;
    unique case (r_state)
      S_LOADJ: w_addr = {2'b00, r_j, r_ph};
      S_SCANK: w_addr = {2'b00, r_k, r_ph};
`ifdef HAMMING_LOC_EN
      S_WRMIN: begin
        w_we = 1'b1;
        unique case (r_wsel)
          2'd1:    begin w_addr = 8'd66; w_wdata = {3'b000, r_minj}; end
          2'd2:    begin w_addr = 8'd67; w_wdata = {3'b000, r_mink}; end
          default: begin w_addr = 8'd64; w_wdata = {3'b000, r_min};  end
        endcase
      end
      S_WRMAX: begin
        w_we = 1'b1;
        unique case (r_wsel)
          2'd1:    begin w_addr = 8'd68; w_wdata = {3'b000, r_maxj}; end
          2'd2:    begin w_addr = 8'd69; w_wdata = {3'b000, r_maxk}; end
          default: begin w_addr = 8'd65; w_wdata = {3'b000, r_max};  end
        endcase
      end
`else
      S_WRMIN: begin
        w_we    = 1'b1;
        w_addr  = 8'd64;
        w_wdata = {3'b000, r_min};
      end
      S_WRMAX: begin
        w_we    = 1'b1;
        w_addr  = 8'd65;
        w_wdata = {3'b000, r_max};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_x    = r_wj ^ {r_khi, w_rdata};
    w_dist = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_dist = w_dist + {4'b0000, w_x[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ph    <= 1'b0;
      r_j     <= 5'd0;
      r_k     <= 5'd0;
      r_wj    <= 16'd0;
      r_khi   <= 8'd0;
      r_min   <= 5'd0;
      r_max   <= 5'd0;
      r_done  <= 1'b0;
`ifdef HAMMING_LOC_EN
      r_minj  <= 5'd0;
      r_mink  <= 5'd0;
      r_maxj  <= 5'd0;
      r_maxk  <= 5'd0;
      r_wsel  <= 2'd0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!start) begin
            r_state <= S_LOADJ;
            r_j     <= 5'd0;
            r_ph    <= 1'b0;
            r_min   <= 5'd16;
            r_max   <= 5'd0;
`ifdef HAMMING_LOC_EN
            r_minj  <= 5'd0;
            r_mink  <= 5'd0;
            r_maxj  <= 5'd0;
            r_maxk  <= 5'd0;
`endif
          end
        end
        S_LOADJ: begin
          if (!r_ph) begin
            r_wj[15:8] <= w_rdata;
            r_ph       <= 1'b1;
          end else begin
            r_wj[7:0] <= w_rdata;
            r_ph      <= 1'b0;
            r_k       <= r_j + 5'd1;
            r_state   <= S_SCANK;
          end
        end
        S_SCANK: begin
          if (!r_ph) begin
            r_khi <= w_rdata;
            r_ph  <= 1'b1;
          end else begin
            r_ph <= 1'b0;
            // Strict compares keep the first pair to reach an extreme.
            if (w_dist < r_min) begin
              r_min  <= w_dist;
`ifdef HAMMING_LOC_EN
              r_minj <= r_j;
              r_mink <= r_k;
`endif
            end
            if (w_dist > r_max) begin
              r_max  <= w_dist;
`ifdef HAMMING_LOC_EN
              r_maxj <= r_j;
              r_maxk <= r_k;
`endif
            end
            if (r_k == 5'd31) begin
              if (r_j < 5'd30) begin
                r_j     <= r_j + 5'd1;
                r_state <= S_LOADJ;
              end else begin
                r_state <= S_WRMIN;
`ifdef HAMMING_LOC_EN
                r_wsel  <= 2'd0;
`endif
              end
            end else begin
              r_k <= r_k + 5'd1;
            end
          end
        end
`ifdef HAMMING_LOC_EN
        S_WRMIN: begin
          if (r_wsel == 2'd2) begin
            r_wsel  <= 2'd0;
            r_state <= S_WRMAX;
          end else begin
            r_wsel <= r_wsel + 2'd1;
          end
        end
        S_WRMAX: begin
          if (r_wsel == 2'd2) begin
            r_wsel  <= 2'd0;
            r_state <= S_DONE;
          end else begin
            r_wsel <= r_wsel + 2'd1;
          end
        end
`else
        S_WRMIN: r_state <= S_WRMAX;
        S_WRMAX: r_state <= S_DONE;
`endif
        S_DONE: begin
          if (start) r_state <= S_ARMED;
          else       r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done = r_done;
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the min/max Hamming distance engine.
// Expected results come from hand values and a popcount model.

module tb_top_level;
`ifdef HAMMING_LOC_EN
  localparam int LAT = 1061;
`else
  localparam int LAT = 1057;
`endif

  logic clk;
  logic rst_n;
  logic start;
  logic done;

  int checks;
  int errors;

  logic [15:0] words [32];
  logic [4:0]  m_min;
  logic [4:0]  m_max;
  int          m_minj, m_mink, m_maxj, m_maxk;

  top_level dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_words();
    for (int i = 0; i < 32; i++) begin
      dut.dataMemory.Core[2*i]   = words[i][15:8];
      dut.dataMemory.Core[2*i+1] = words[i][7:0];
    end
    dut.dataMemory.Core[64] = 8'd16;
    dut.dataMemory.Core[65] = 8'd0;
  endtask

  task automatic model();
    int d;
    m_min = 5'd16;
    m_max = 5'd0;
    m_minj = 0; m_mink = 0; m_maxj = 0; m_maxk = 0;
    for (int j = 0; j < 31; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = $countones(words[j] ^ words[k]);
        if (d < int'(m_min)) begin
          m_min = 5'(d); m_minj = j; m_mink = k;
        end
        if (d > int'(m_max)) begin
          m_max = 5'(d); m_maxj = j; m_maxk = k;
        end
      end
    end
  endtask

  task automatic launch();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    @(posedge clk);
    for (int n = 1; n <= 1300; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL idle_done got %b want 0", done);
    end
  endtask

  task automatic test_zero();
    int cyc;
    for (int i = 0; i < 32; i++) words[i] = 16'h0000;
    load_words();
    launch();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL zero_armed_done got %b want 0", done);
    end
    wait_done(cyc);
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL zero_latency got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== 8'd0) begin
      errors++; $display("FAIL zero_min got %0d want 0", dut.dataMemory.Core[64]);
    end
    checks++;
    if (dut.dataMemory.Core[65] !== 8'd0) begin
      errors++; $display("FAIL zero_max got %0d want 0", dut.dataMemory.Core[65]);
    end
  endtask

  task automatic test_onehot();
    int cyc;
    for (int i = 0; i < 32; i++) words[i] = 16'h0000;
    words[0] = 16'hFFFF;
    load_words();
    launch();
    wait_done(cyc);
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL onehot_latency got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== 8'd0) begin
      errors++; $display("FAIL onehot_min got %0d want 0", dut.dataMemory.Core[64]);
    end
    checks++;
    if (dut.dataMemory.Core[65] !== 8'd16) begin
      errors++; $display("FAIL onehot_max got %0d want 16", dut.dataMemory.Core[65]);
    end
`ifdef HAMMING_LOC_EN
    checks++;
    if (dut.dataMemory.Core[68] !== 8'd0 || dut.dataMemory.Core[69] !== 8'd1) begin
      errors++;
      $display("FAIL onehot_maxpair got (%0d,%0d) want (0,1)",
               dut.dataMemory.Core[68], dut.dataMemory.Core[69]);
    end
`endif
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dut.dataMemory.Core[i] !== (i == 0 || i == 1 ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL onehot_operand_kept addr %0d got %h", i, dut.dataMemory.Core[i]);
      end
    end
  endtask

  task automatic test_ramp();
    int cyc;
    for (int i = 0; i < 32; i++) words[i] = 16'(i);
    load_words();
    launch();
    wait_done(cyc);
    checks++;
    if (dut.dataMemory.Core[64] !== 8'd1) begin
      errors++; $display("FAIL ramp_min got %0d want 1", dut.dataMemory.Core[64]);
    end
    checks++;
    if (dut.dataMemory.Core[65] !== 8'd5) begin
      errors++; $display("FAIL ramp_max got %0d want 5", dut.dataMemory.Core[65]);
    end
`ifdef HAMMING_LOC_EN
    checks++;
    if (dut.dataMemory.Core[66] !== 8'd0 || dut.dataMemory.Core[67] !== 8'd1) begin
      errors++;
      $display("FAIL ramp_minpair got (%0d,%0d) want (0,1)",
               dut.dataMemory.Core[66], dut.dataMemory.Core[67]);
    end
    checks++;
    if (dut.dataMemory.Core[68] !== 8'd0 || dut.dataMemory.Core[69] !== 8'd31) begin
      errors++;
      $display("FAIL ramp_maxpair got (%0d,%0d) want (0,31)",
               dut.dataMemory.Core[68], dut.dataMemory.Core[69]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      if (r == 3) words[7] = words[20];
      load_words();
      model();
      launch();
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL b2b_armed_done run %0d got %b want 0", r, done);
      end
      wait_done(cyc);
      checks++;
      if (cyc != LAT) begin
        errors++; $display("FAIL b2b_latency run %0d got %0d want %0d", r, cyc, LAT);
      end
      checks++;
      if (dut.dataMemory.Core[64] !== {3'b000, m_min}) begin
        errors++;
        $display("FAIL b2b_min run %0d got %0d want %0d", r, dut.dataMemory.Core[64], m_min);
      end
      checks++;
      if (dut.dataMemory.Core[65] !== {3'b000, m_max}) begin
        errors++;
        $display("FAIL b2b_max run %0d got %0d want %0d", r, dut.dataMemory.Core[65], m_max);
      end
`ifdef HAMMING_LOC_EN
      checks++;
      if (dut.dataMemory.Core[66] !== 8'(m_minj) || dut.dataMemory.Core[67] !== 8'(m_mink) ||
          dut.dataMemory.Core[68] !== 8'(m_maxj) || dut.dataMemory.Core[69] !== 8'(m_maxk)) begin
        errors++;
        $display("FAIL b2b_pairs run %0d got %0d %0d %0d %0d want %0d %0d %0d %0d", r,
                 dut.dataMemory.Core[66], dut.dataMemory.Core[67],
                 dut.dataMemory.Core[68], dut.dataMemory.Core[69],
                 m_minj, m_mink, m_maxj, m_maxk);
      end
`endif
    end
  endtask

  task automatic test_hold();
    int drops;
    drops = 0;
    dut.dataMemory.Core[64] = 8'hAA;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL hold_done low cycles got %0d want 0", drops);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== 8'hAA) begin
      errors++; $display("FAIL hold_norerun got %h want aa", dut.dataMemory.Core[64]);
    end
  endtask

  task automatic test_toggle();
    int cyc;
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    load_words();
    model();
    launch();
    @(posedge clk);
    cyc = -1;
    for (int n = 1; n <= 1300; n++) begin
      @(posedge clk); #1;
      if (n == 100 || n == 600 || n == 1050) start = 1'b1;
      if (n == 103 || n == 601 || n == 1052) start = 1'b0;
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL toggle_latency got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== {3'b000, m_min} ||
        dut.dataMemory.Core[65] !== {3'b000, m_max}) begin
      errors++;
      $display("FAIL toggle_result got %0d/%0d want %0d/%0d",
               dut.dataMemory.Core[64], dut.dataMemory.Core[65], m_min, m_max);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    // Reset while results are held.
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_in_done got %b want 0", done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    load_words();
    launch();
    repeat (300) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || dut.r_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid got done %b state %0d want 0 0", done, dut.r_state);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== 8'd16) begin
      errors++; $display("FAIL rst_mid_mem got %0d want 16", dut.dataMemory.Core[64]);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got %b want 0", done);
    end
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    load_words();
    model();
    launch();
    wait_done(cyc);
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL rst_rerun_latency got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (dut.dataMemory.Core[64] !== {3'b000, m_min} ||
        dut.dataMemory.Core[65] !== {3'b000, m_max}) begin
      errors++;
      $display("FAIL rst_rerun_result got %0d/%0d want %0d/%0d",
               dut.dataMemory.Core[64], dut.dataMemory.Core[65], m_min, m_max);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    test_reset();
    test_zero();
    test_onehot();
    test_ramp();
    test_back_to_back();
    test_hold();
    test_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/top_level.md
# top_level

Fixed-function Hamming-distance engine for the program-1 (min/max Hamming distance) workload. It is the top of the design. It owns a 256×8 data memory holding 32 16-bit operands. On a start handshake it finds the minimum and maximum pairwise Hamming distance over all 496 operand pairs, writes both results back to data memory and raises `done`. An instruction-store instance is kept so bench program preloads still resolve, but its contents do not affect behaviour.

## Interface
- No parameters; all sizes fixed.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  run request; a run is armed by high and launched by the following low.
- `done`  output  1  high when results are valid in memory; reset value 0.
- Hierarchy (bench-visible):
  - `dataMemory.Core[0:255]`: 8-bit array, combinational read, synchronous write, not reset.
  - `instrMem1.Core[0:1023]`: 9-bit array, preload only, ignored by the engine.

## Operation
- Operand i (i = 0..31) is W[i] = {Core[2i], Core[2i+1]}; 2i is the high byte.
- Distance d(j,k) = popcount(W[j] XOR W[k]), range 0..16, held in 5 bits.
- Run loop:
  - Accumulators initialise to Min = 16, Max = 0.
  - Visit j = 0..30 outer, k = j+1..31 inner.
  - Update with strict compares: d < Min replaces Min; d > Max replaces Max.
  - Tie rule: the first pair reaching an extreme is kept.
- Write-back: Core[64] = {3'b0, Min}, Core[65] = {3'b0, Max}.
- Core[0..63] is never written. Without the configuration macro, no other location is written.
- FSM states: IDLE, ARMED, LOADJ, SCANK, WRMIN, WRMAX, DONE.
  - IDLE: `start`=1 → ARMED.
  - ARMED: `start`=0 → LOADJ with j=0; Min/Max initialised.
  - LOADJ: 2 cycles, latches high then low byte of W[j] into a register; → SCANK with k=j+1.
  - SCANK: 2 cycles per k (high byte, then low byte plus compare/update).
    - After k=31: if j<30, j++ and → LOADJ; else → WRMIN.
  - WRMIN: 1 cycle, writes Core[64]; → WRMAX.
  - WRMAX: 1 cycle, writes Core[65]; → DONE.
  - DONE: `done`=1; hold while `start`=0; `start`=1 → ARMED with `done`=0 in that same cycle.
- `start` changes in LOADJ through WRMAX are ignored; a run always completes.
- Reset mid-run (async): FSM → IDLE, `done`=0, j/k/Min/Max cleared. Memory contents untouched; the partial run is abandoned.

## Timing
- `done` is registered: low in every state except DONE.
- Latency from the first edge sampling `start`=0 in ARMED to `done`=1:
  - 31 LOADJ × 2 cycles + 496 pairs × 2 cycles = 1054 cycles.
  - Plus 2 write cycles, plus 1 cycle into DONE: 1057 cycles total.
- Memory may be preloaded externally while the FSM is in IDLE, ARMED or DONE; the engine reads nothing in those states.
- Back-to-back runs: `start` high then low again relaunches with fresh Min/Max; there is no dependence on the previous run's results.

## Configuration
- `HAMMING_LOC_EN` defined: WRMIN/WRMAX also write pair indices, adding 4 cycles of latency (1061 total):
  - Core[66] = Min j, Core[67] = Min k.
  - Core[68] = Max j, Core[69] = Max k.
  - Each index is zero-extended 5-bit; values are the pair kept under the tie rule.
- Undefined: indices are not tracked and Core[66..255] are never written.

## Test plan
- All 32 words 0x0000 → Core[64]=0, Core[65]=0; `done` rises exactly 1057 cycles after launch.
- W[0]=0xFFFF, all others 0x0000 → Min=0, Max=16; with `HAMMING_LOC_EN`, Max pair j=0, k=1.
- W[i]=i (i = 0..31) → Min=1, Max=5; with `HAMMING_LOC_EN`, Min pair (0,1) and Max pair (0,31).
- Ten consecutive runs with random data, `start` 1→0 per run, Core[64]/[65] preset to 16/0 before each:
  - Each result matches a software popcount model.
  - `done` is 0 from ARMED entry until completion.
- Handshake: `start` held 0 after DONE → `done` stays 1 and there is no rerun. `start` toggling mid-run → ignored; results are still correct.
- `rst_n` pulsed low during SCANK → `done`=0 immediately and FSM in IDLE; a fresh start/launch then produces correct results.
